// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: two 2-entry result FIFOs (ALU, load unit), round-robin grant, registered write port.
// Define WB_BYPASS_EN to add the forwarding compare ports (fwd_addr_*/fwd_hit_*/fwd_data_*).
`timescale 1ns/1ps
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0] fwd_addr_a_i,
  input  logic [ADDR_W-1:0] fwd_addr_b_i,
  output logic              fwd_hit_a_o,
  output logic              fwd_hit_b_o,
  output logic [DATA_W-1:0] fwd_data_a_o,
  output logic [DATA_W-1:0] fwd_data_b_o,
`endif
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic [ADDR_W-1:0] alu_fifo_addr_q [2];
  logic [DATA_W-1:0] alu_fifo_data_q [2];
  logic              alu_wr_ptr_q, alu_wr_ptr_d;
  logic              alu_rd_ptr_q, alu_rd_ptr_d;
  logic [1:0]        alu_cnt_q, alu_cnt_d;

  logic [ADDR_W-1:0] mem_fifo_addr_q [2];
  logic [DATA_W-1:0] mem_fifo_data_q [2];
  logic              mem_wr_ptr_q, mem_wr_ptr_d;
  logic              mem_rd_ptr_q, mem_rd_ptr_d;
  logic [1:0]        mem_cnt_q, mem_cnt_d;

  src_e              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              alu_push_s, mem_push_s;
  logic              alu_ne_s, mem_ne_s;
  logic              grant_alu_s, grant_mem_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  // Ready comes from the registered count only, so it never depends on this cycle's pop.
  assign alu_ready_o = (alu_cnt_q != 2'd2);
  assign mem_ready_o = (mem_cnt_q != 2'd2);
  assign alu_push_s  = alu_valid_i && alu_ready_o;
  assign mem_push_s  = mem_valid_i && mem_ready_o;
  assign alu_ne_s    = (alu_cnt_q != 2'd0);
  assign mem_ne_s    = (mem_cnt_q != 2'd0);

  always_comb begin
    alu_wr_ptr_d = alu_wr_ptr_q;
    alu_rd_ptr_d = alu_rd_ptr_q;
    alu_cnt_d    = alu_cnt_q;
    if (alu_push_s) begin
      alu_wr_ptr_d = ~alu_wr_ptr_q;
    end else begin
      alu_wr_ptr_d = alu_wr_ptr_q;
    end
    if (grant_alu_s) begin
      alu_rd_ptr_d = ~alu_rd_ptr_q;
    end else begin
      alu_rd_ptr_d = alu_rd_ptr_q;
    end
    case ({alu_push_s, grant_alu_s})
      2'b10:   alu_cnt_d = alu_cnt_q + 2'd1;
      2'b01:   alu_cnt_d = alu_cnt_q - 2'd1;
      default: alu_cnt_d = alu_cnt_q;
    endcase
  end

  always_comb begin
    mem_wr_ptr_d = mem_wr_ptr_q;
    mem_rd_ptr_d = mem_rd_ptr_q;
    mem_cnt_d    = mem_cnt_q;
    if (mem_push_s) begin
      mem_wr_ptr_d = ~mem_wr_ptr_q;
    end else begin
      mem_wr_ptr_d = mem_wr_ptr_q;
    end
    if (grant_mem_s) begin
      mem_rd_ptr_d = ~mem_rd_ptr_q;
    end else begin
      mem_rd_ptr_d = mem_rd_ptr_q;
    end
    case ({mem_push_s, grant_mem_s})
      2'b10:   mem_cnt_d = mem_cnt_q + 2'd1;
      2'b01:   mem_cnt_d = mem_cnt_q - 2'd1;
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // Round-robin: on a tie the source not granted last time wins; last_grant moves only on a grant.
  always_comb begin
    grant_alu_s  = 1'b0;
    grant_mem_s  = 1'b0;
    last_grant_d = last_grant_q;
    if (alu_ne_s && mem_ne_s) begin
      if (last_grant_q == SRC_ALU) begin
        grant_mem_s = 1'b1;
      end else begin
        grant_alu_s = 1'b1;
      end
    end else if (alu_ne_s) begin
      grant_alu_s = 1'b1;
    end else if (mem_ne_s) begin
      grant_mem_s = 1'b1;
    end else begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
    end
    if (grant_alu_s) begin
      last_grant_d = SRC_ALU;
    end else if (grant_mem_s) begin
      last_grant_d = SRC_MEM;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // A granted head aimed at r0 is still popped, but never reaches the write port.
  always_comb begin
    head_addr_s = alu_fifo_addr_q[alu_rd_ptr_q];
    head_data_s = alu_fifo_data_q[alu_rd_ptr_q];
    if (grant_mem_s) begin
      head_addr_s = mem_fifo_addr_q[mem_rd_ptr_q];
      head_data_s = mem_fifo_data_q[mem_rd_ptr_q];
    end else begin
      head_addr_s = alu_fifo_addr_q[alu_rd_ptr_q];
      head_data_s = alu_fifo_data_q[alu_rd_ptr_q];
    end
    wr_en_d   = (grant_alu_s || grant_mem_s) && (head_addr_s != {ADDR_W{1'b0}});
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = head_addr_s;
      wr_data_d = head_data_s;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        alu_fifo_addr_q[i] <= {ADDR_W{1'b0}};
        alu_fifo_data_q[i] <= {DATA_W{1'b0}};
        mem_fifo_addr_q[i] <= {ADDR_W{1'b0}};
        mem_fifo_data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (alu_push_s) begin
        alu_fifo_addr_q[alu_wr_ptr_q] <= alu_addr_i;
        alu_fifo_data_q[alu_wr_ptr_q] <= alu_data_i;
      end
      if (mem_push_s) begin
        mem_fifo_addr_q[mem_wr_ptr_q] <= mem_addr_i;
        mem_fifo_data_q[mem_wr_ptr_q] <= mem_data_i;
      end
    end
  end

  // Reset starts last_grant at ALU so the first tie goes to the load unit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_wr_ptr_q <= 1'b0;
      alu_rd_ptr_q <= 1'b0;
      alu_cnt_q    <= 2'd0;
      mem_wr_ptr_q <= 1'b0;
      mem_rd_ptr_q <= 1'b0;
      mem_cnt_q    <= 2'd0;
      last_grant_q <= SRC_ALU;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= {DATA_W{1'b0}};
    end else begin
      alu_wr_ptr_q <= alu_wr_ptr_d;
      alu_rd_ptr_q <= alu_rd_ptr_d;
      alu_cnt_q    <= alu_cnt_d;
      mem_wr_ptr_q <= mem_wr_ptr_d;
      mem_rd_ptr_q <= mem_rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = alu_ne_s || mem_ne_s || wr_en_q;

`ifdef WB_BYPASS_EN
  // Lets the consuming stage pick up the value being written this very cycle.
  assign fwd_hit_a_o  = wr_en_q && (wr_addr_q == fwd_addr_a_i) && (wr_addr_q != {ADDR_W{1'b0}});
  assign fwd_hit_b_o  = wr_en_q && (wr_addr_q == fwd_addr_b_i) && (wr_addr_q != {ADDR_W{1'b0}});
  assign fwd_data_a_o = wr_data_q;
  assign fwd_data_b_o = wr_data_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: scoreboard queues filled at stimulus time, compared at write-port output.
`timescale 1ns/1ps
module tb_reg_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr, wr_addr;
  logic [DW-1:0] alu_data, mem_data, wr_data;
  logic          wr_en, busy;
`ifdef WB_BYPASS_EN
  logic [AW-1:0] fwd_addr_a, fwd_addr_b;
  logic          fwd_hit_a, fwd_hit_b;
  logic [DW-1:0] fwd_data_a, fwd_data_b;
`endif

  int total = 0;
  int bad = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_alu_q[$];
  logic [AW+DW-1:0] exp_mem_q[$];

  always #5 clk = ~clk;

  reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
`ifdef WB_BYPASS_EN
    .fwd_addr_a_i(fwd_addr_a), .fwd_addr_b_i(fwd_addr_b),
    .fwd_hit_a_o(fwd_hit_a), .fwd_hit_b_o(fwd_hit_b),
    .fwd_data_a_o(fwd_data_a), .fwd_data_b_o(fwd_data_b),
`endif
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
  );

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    repeat (2) @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
    total++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_bus got=%0d/%h want=0/0", wr_addr, wr_data); end
    total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b want=11", alu_ready, mem_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_release_wr got=%b want=0", wr_en); end
  endtask

  task automatic test_single();
    logic [AW+DW-1:0] e;
    exp_q.delete();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_00F0;
    exp_q.push_back({5'd3, 32'h0000_00F0});
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", wr_en); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    @(negedge clk);
    total++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL single_wr_en got=%b want=1", wr_en);
    end else begin
      e = exp_q.pop_front();
      if ({wr_addr, wr_data} !== e) begin bad++; $display("FAIL single_data got=%0d/%h want=%0d/%h", wr_addr, wr_data, e[DW+:AW], e[DW-1:0]); end
    end
    @(negedge clk);
    total++; if (wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after got=%b/%b want=0/0", wr_en, busy); end
  endtask

  task automatic test_tie();
    int ai = 0, mi = 0, writes = 0, cyc = 0;
    bit acc_a, acc_m, gap = 1'b0;
    logic [AW+DW-1:0] e;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({5'(5 + k), 32'hB000_0000 + 32'(5 + k)});
      exp_q.push_back({5'(1 + k), 32'hA000_0000 + 32'(1 + k)});
    end
    while ((ai < 4 || mi < 4 || busy === 1'b1) && cyc < 40) begin
      alu_valid = (ai < 4); alu_addr = 5'(1 + ai); alu_data = 32'hA000_0000 + 32'(1 + ai);
      mem_valid = (mi < 4); mem_addr = 5'(5 + mi); mem_data = 32'hB000_0000 + 32'(5 + mi);
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
      @(negedge clk);
      cyc++;
      if (acc_a) ai++;
      if (acc_m) mi++;
      if (wr_en === 1'b1) begin
        writes++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL tie_extra got=%0d want=none", wr_addr);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin bad++; $display("FAIL tie_order got=%0d/%h want=%0d/%h", wr_addr, wr_data, e[DW+:AW], e[DW-1:0]); end
        end
      end else if (writes > 0 && writes < 8) begin
        gap = 1'b1;
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    total++; if (cyc >= 40) begin bad++; $display("FAIL tie_timeout got=%0d want<40", cyc); end
    total++; if (gap) begin bad++; $display("FAIL tie_gap got=gap want=continuous"); end
    total++; if (writes != 8 || exp_q.size() != 0) begin bad++; $display("FAIL tie_count got=%0d left=%0d want=8/0", writes, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int ai = 0, mi = 0, writes = 0, cyc = 0;
    bit acc_a, acc_m, alu_lo = 1'b0, mem_lo = 1'b0;
    logic [AW+DW-1:0] e;
    exp_alu_q.delete(); exp_mem_q.delete();
    while ((ai < 6 || mi < 6 || busy === 1'b1) && cyc < 60) begin
      alu_valid = (ai < 6); alu_addr = 5'(10 + ai); alu_data = 32'hC000_0000 + 32'(ai * 7);
      mem_valid = (mi < 6); mem_addr = 5'(16 + mi); mem_data = 32'hD000_0000 + 32'(mi * 13);
      if (alu_ready === 1'b0) alu_lo = 1'b1;
      if (mem_ready === 1'b0) mem_lo = 1'b1;
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
      if (acc_a) exp_alu_q.push_back({alu_addr, alu_data});
      if (acc_m) exp_mem_q.push_back({mem_addr, mem_data});
      @(negedge clk);
      cyc++;
      if (acc_a) ai++;
      if (acc_m) mi++;
      if (wr_en === 1'b1) begin
        writes++;
        total++;
        if (wr_addr >= 5'd10 && wr_addr <= 5'd15 && exp_alu_q.size() != 0) begin
          e = exp_alu_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin bad++; $display("FAIL bp_alu_order got=%0d/%h want=%0d/%h", wr_addr, wr_data, e[DW+:AW], e[DW-1:0]); end
        end else if (wr_addr >= 5'd16 && wr_addr <= 5'd21 && exp_mem_q.size() != 0) begin
          e = exp_mem_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin bad++; $display("FAIL bp_mem_order got=%0d/%h want=%0d/%h", wr_addr, wr_data, e[DW+:AW], e[DW-1:0]); end
        end else begin
          bad++; $display("FAIL bp_unexpected got=%0d/%h want=queued beat", wr_addr, wr_data);
        end
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    total++; if (cyc >= 60) begin bad++; $display("FAIL bp_timeout got=%0d want<60", cyc); end
    total++; if (!alu_lo || !mem_lo) begin bad++; $display("FAIL bp_ready_drop got=%b%b want=11", alu_lo, mem_lo); end
    total++; if (writes != 12 || exp_alu_q.size() != 0 || exp_mem_q.size() != 0) begin
      bad++; $display("FAIL bp_count got=%0d left=%0d/%0d want=12/0/0", writes, exp_alu_q.size(), exp_mem_q.size());
    end
  endtask

  task automatic test_r0_drop();
    int writes = 0;
    logic [AW+DW-1:0] e;
    exp_q.delete();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h15;
    @(negedge clk);
    alu_addr = 5'd2; alu_data = 32'h11;
    exp_q.push_back({5'd2, 32'h11});
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL r0_early got=%b want=0", wr_en); end
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL r0_written got=%b addr=%0d want=0", wr_en, wr_addr); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        writes++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL r0_extra got=%0d want=none", wr_addr);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin bad++; $display("FAIL r0_next got=%0d/%h want=%0d/%h", wr_addr, wr_data, e[DW+:AW], e[DW-1:0]); end
        end
      end
    end
    total++; if (writes != 1 || busy !== 1'b0) begin bad++; $display("FAIL r0_count got=%0d/%b want=1/0", writes, busy); end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h9999_0000;
    mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h1212_0000;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1 || (alu_ready & mem_ready) !== 1'b0) begin bad++; $display("FAIL mid_prefill got=%b/%b%b want=1/not both ready", busy, alu_ready, mem_ready); end
    #2 rst = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_out got=%b/%b want=0/0", wr_en, busy); end
    total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b%b want=11", alu_ready, mem_ready); end
    total++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin bad++; $display("FAIL mid_rst_bus got=%0d/%h want=0/0", wr_addr, wr_data); end
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_release got=%b/%b want=0/0", wr_en, busy); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    int cyc = 0;
    fwd_addr_a = 5'd5; fwd_addr_b = 5'd6;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (fwd_hit_a !== 1'b0) begin bad++; $display("FAIL byp_idle got=%b want=0", fwd_hit_a); end
    while (wr_en !== 1'b1 && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL byp_timeout got=%b want=1", wr_en); end
    total++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'h11) begin bad++; $display("FAIL byp_hit_a got=%b/%h want=1/00000011", fwd_hit_a, fwd_data_a); end
    total++; if (fwd_hit_b !== 1'b0) begin bad++; $display("FAIL byp_hit_b got=%b want=0", fwd_hit_b); end
    @(negedge clk);
    total++; if (fwd_hit_a !== 1'b0) begin bad++; $display("FAIL byp_after got=%b want=0", fwd_hit_a); end
  endtask
`endif

  initial begin
    rst = 1'b1;
`ifdef WB_BYPASS_EN
    fwd_addr_a = '0; fwd_addr_b = '0;
`endif
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_r0_drop();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
